// File: rtl/counter_bound.sv
// Bounded up/down counter with programmable step, bounds and wrap/saturate mode.
// Its registered wrap pulse can feed the up input of another instance to build row/column counters.
module counter_bound #(
    parameter int width_p      = 8,
    parameter int step_width_p = 4,
    parameter int reset_val_p  = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [width_p-1:0]      load_val_i,
    input  logic [width_p-1:0]      min_val_i,
    input  logic [width_p-1:0]      max_val_i,
    input  logic [step_width_p-1:0] step_i,
    input  logic                    sat_mode_i,
    input  logic                    up_i,
    input  logic                    down_i,
    output logic [width_p-1:0]      count_o,
    output logic                    wrap_o,
    output logic                    sat_o,
    output logic                    at_max_o,
    output logic                    at_min_o
);

    localparam logic [width_p-1:0] ResetVal = width_p'(reset_val_p);

    typedef logic [width_p:0] ext_t;

    logic [width_p-1:0] count_r, count_n;
    logic               wrap_r, wrap_n;
    logic               sat_r, sat_n;

    ext_t cnt_x, min_x, max_x, step_x;
    ext_t sum_x, span_x, over_x, deficit_x;

    // One extra bit keeps every intermediate sum and difference from overflowing.
    assign cnt_x     = {1'b0, count_r};
    assign min_x     = {1'b0, min_val_i};
    assign max_x     = {1'b0, max_val_i};
    assign step_x    = ext_t'(step_i);
    assign sum_x     = cnt_x + step_x;
    assign span_x    = max_x - min_x;
    assign over_x    = sum_x - max_x - 1'b1;
    assign deficit_x = min_x + step_x - cnt_x - 1'b1;

    always_comb begin
        count_n = count_r;
        wrap_n  = 1'b0;
        sat_n   = 1'b0;
        if (clear_i) begin
            count_n = ResetVal;
        end else if (load_i) begin
            count_n = load_val_i;
        end else if (up_i ^ down_i) begin
            if (cnt_x < min_x || cnt_x > max_x) begin
                count_n = up_i ? min_val_i : max_val_i;
            end else if (up_i) begin
                if (sum_x <= max_x) begin
                    count_n = width_p'(sum_x);
                end else if (sat_mode_i) begin
                    count_n = max_val_i;
                    sat_n   = 1'b1;
                end else begin
                    // A step larger than the range lands on the bound instead of wrapping twice.
                    count_n = (over_x > span_x) ? min_val_i : width_p'(min_x + over_x);
                    wrap_n  = 1'b1;
                end
            end else begin
                if (cnt_x >= min_x + step_x) begin
                    count_n = width_p'(cnt_x - step_x);
                end else if (sat_mode_i) begin
                    count_n = min_val_i;
                    sat_n   = 1'b1;
                end else begin
                    count_n = (deficit_x > span_x) ? max_val_i : width_p'(max_x - deficit_x);
                    wrap_n  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= ResetVal;
            wrap_r  <= 1'b0;
            sat_r   <= 1'b0;
        end else begin
            count_r <= count_n;
            wrap_r  <= wrap_n;
            sat_r   <= sat_n;
        end
    end

    assign count_o  = count_r;
    assign wrap_o   = wrap_r;
    assign sat_o    = sat_r;
    assign at_max_o = (count_r == max_val_i);
    assign at_min_o = (count_r == min_val_i);

endmodule

// File: tb/tb_counter_bound.sv
// Directed self-checking bench for counter_bound (width 8, step width 4, reset value 5).
// Expected values are hand-computed from the counting rules for each step.
module tb_counter_bound;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       clear_i;
    logic       load_i;
    logic [7:0] load_val_i;
    logic [7:0] min_val_i;
    logic [7:0] max_val_i;
    logic [3:0] step_i;
    logic       sat_mode_i;
    logic       up_i;
    logic       down_i;
    logic [7:0] count_o;
    logic       wrap_o;
    logic       sat_o;
    logic       at_max_o;
    logic       at_min_o;

    int checks = 0;
    int errors = 0;

    counter_bound #(
        .width_p      (8),
        .step_width_p (4),
        .reset_val_p  (5)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (clear_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .min_val_i  (min_val_i),
        .max_val_i  (max_val_i),
        .step_i     (step_i),
        .sat_mode_i (sat_mode_i),
        .up_i       (up_i),
        .down_i     (down_i),
        .count_o    (count_o),
        .wrap_o     (wrap_o),
        .sat_o      (sat_o),
        .at_max_o   (at_max_o),
        .at_min_o   (at_min_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] cnt, input logic wrap, input logic sat);
        check_output({tag, " count"}, 32'(count_o), 32'(cnt));
        check_output({tag, " wrap"}, 32'(wrap_o), 32'(wrap));
        check_output({tag, " sat"}, 32'(sat_o), 32'(sat));
    endtask

    initial begin
        reset_i = 1'b1; clear_i = 1'b0; load_i = 1'b0; load_val_i = 8'd0;
        min_val_i = 8'd0; max_val_i = 8'd255; step_i = 4'd0;
        sat_mode_i = 1'b0; up_i = 1'b0; down_i = 1'b0;

        // Reset state
        #12;
        check_state("reset", 8'd5, 1'b0, 1'b0);
        check_output("reset at_min", 32'(at_min_o), 32'd0);
        reset_i = 1'b0;
        min_val_i = 8'd2; max_val_i = 8'd9;

        // Load 9, then saturate at max to get a live pulse before the mid-cycle reset
        load_i = 1'b1; load_val_i = 8'd9;
        tick();
        load_i = 1'b0;
        check_state("load9", 8'd9, 1'b0, 1'b0);
        check_output("load9 at_max", 32'(at_max_o), 32'd1);
        sat_mode_i = 1'b1; up_i = 1'b1; step_i = 4'd1;
        tick();
        check_state("sat at max", 8'd9, 1'b0, 1'b1);
        #2;
        reset_i = 1'b1;
        #1;
        check_state("async reset", 8'd5, 1'b0, 1'b0);
        tick();
        check_state("reset held", 8'd5, 1'b0, 1'b0);
        #4;
        reset_i = 1'b0;
        tick();
        check_state("after release", 8'd6, 1'b0, 1'b0);

        // Wrap up: 2..9, step 3
        sat_mode_i = 1'b0; step_i = 4'd3;
        load_i = 1'b1; load_val_i = 8'd8;
        tick();
        load_i = 1'b0;
        check_state("load8", 8'd8, 1'b0, 1'b0);
        tick();
        check_state("wrap up", 8'd3, 1'b1, 1'b0);
        tick();
        check_state("up after wrap", 8'd6, 1'b0, 1'b0);

        // Wrap down: 2..9, step 3
        up_i = 1'b0; down_i = 1'b1;
        tick();
        check_state("down 6->3", 8'd3, 1'b0, 1'b0);
        tick();
        check_state("wrap down", 8'd8, 1'b1, 1'b0);

        // Steps larger than the range clamp to the opposite bound
        load_i = 1'b1; load_val_i = 8'd3;
        tick();
        load_i = 1'b0;
        check_state("load3 clears pulse", 8'd3, 1'b0, 1'b0);
        step_i = 4'd15;
        tick();
        check_state("big step down", 8'd9, 1'b1, 1'b0);
        up_i = 1'b1; down_i = 1'b0;
        tick();
        check_state("big step up", 8'd2, 1'b1, 1'b0);

        // Saturate over the full 0..255 range
        min_val_i = 8'd0; max_val_i = 8'd255; sat_mode_i = 1'b1;
        load_i = 1'b1; load_val_i = 8'd250;
        tick();
        load_i = 1'b0;
        check_state("load250", 8'd250, 1'b0, 1'b0);
        tick();
        check_state("sat up", 8'd255, 1'b0, 1'b1);
        tick();
        check_state("sat repeat", 8'd255, 1'b0, 1'b1);
        up_i = 1'b1; down_i = 1'b1;
        tick();
        check_state("up+down hold", 8'd255, 1'b0, 1'b0);
        up_i = 1'b0;
        tick();
        check_state("down from max", 8'd240, 1'b0, 1'b0);

        // Priority: clear > load > count
        clear_i = 1'b1; load_i = 1'b1; load_val_i = 8'd200; up_i = 1'b1; down_i = 1'b0;
        tick();
        check_state("clear wins", 8'd5, 1'b0, 1'b0);
        clear_i = 1'b0;
        tick();
        check_state("load wins", 8'd200, 1'b0, 1'b0);
        load_val_i = 8'd255;
        tick();
        load_i = 1'b0; step_i = 4'd0;
        tick();
        check_state("step0 at max", 8'd255, 1'b0, 1'b0);

        // Out-of-range starts and bound flags
        min_val_i = 8'd2; max_val_i = 8'd9; sat_mode_i = 1'b0; step_i = 4'd3;
        load_i = 1'b1; load_val_i = 8'd20;
        tick();
        load_i = 1'b0;
        check_state("load20", 8'd20, 1'b0, 1'b0);
        tick();
        check_state("oor up", 8'd2, 1'b0, 1'b0);
        check_output("oor up at_min", 32'(at_min_o), 32'd1);
        load_i = 1'b1;
        tick();
        load_i = 1'b0; up_i = 1'b0; down_i = 1'b1;
        tick();
        check_state("oor down", 8'd9, 1'b0, 1'b0);
        check_output("oor down at_max", 32'(at_max_o), 32'd1);
        down_i = 1'b0;
        max_val_i = 8'd12;
        #1;
        check_output("max moved at_max", 32'(at_max_o), 32'd0);
        check_output("max moved at_min", 32'(at_min_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
